// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for a 3-bit-speed, 32-clock-period PWM generator.
// Ramps the generator speed one step per STEP_PERIODS periods and holds it off at speed 0.
module pwm_ramp_ctrl #(
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_speed,
    output logic       cmd_ready,
    input  logic       stop,
    output logic       pwm_hold,
    output logic [2:0] speed,
    output logic       busy,
    output logic       at_target
);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_PERIODS - 1);

    state_t     state;
    logic [2:0] target;
    logic [4:0] phase;
    logic [7:0] step_cnt;

    logic       accept;
    logic       terminal;
    logic       step_due;
    logic [2:0] speed_up;
    logic [2:0] speed_dn;

    assign cmd_ready = ((state == IDLE) || (state == HOLD)) && !stop;
    assign busy      = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign at_target = !busy && (speed == target);

    // Terminal cycle mirrors the generator's last count before its period restarts.
    assign accept   = cmd_valid && cmd_ready;
    assign terminal = (phase == 5'd31) && !pwm_hold;
    assign step_due = terminal && (step_cnt == STEP_LAST);
    assign speed_up = speed + 3'd1;
    assign speed_dn = speed - 3'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            speed    <= 3'd0;
            target   <= 3'd0;
            pwm_hold <= 1'b1;
            phase    <= 5'd0;
            step_cnt <= 8'd0;
        end else if (stop) begin
            state    <= IDLE;
            speed    <= 3'd0;
            target   <= 3'd0;
            pwm_hold <= 1'b1;
            phase    <= 5'd0;
            step_cnt <= 8'd0;
        end else begin
            if (!pwm_hold)
                phase <= phase + 5'd1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        target <= cmd_speed;
                        if (cmd_speed != 3'd0) begin
                            pwm_hold <= 1'b0;
                            phase    <= 5'd0;
                            step_cnt <= 8'd0;
                            state    <= RAMP_UP;
                        end
                    end
                end
                HOLD: begin
                    // Phase keeps running so the generator never sees a truncated period.
                    if (accept) begin
                        target   <= cmd_speed;
                        step_cnt <= 8'd0;
                        if (cmd_speed > speed)
                            state <= RAMP_UP;
                        else if (cmd_speed < speed)
                            state <= RAMP_DOWN;
                    end
                end
                RAMP_UP: begin
                    if (step_due) begin
                        step_cnt <= 8'd0;
                        speed    <= speed_up;
                        if (speed_up == target)
                            state <= HOLD;
                    end else if (terminal) begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                RAMP_DOWN: begin
                    if (step_due) begin
                        step_cnt <= 8'd0;
                        speed    <= speed_dn;
                        if (speed_dn == target) begin
                            // Reaching zero parks the generator on the same edge.
                            if (target == 3'd0) begin
                                state    <= IDLE;
                                pwm_hold <= 1'b1;
                                phase    <= 5'd0;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end else if (terminal) begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (STEP_PERIODS 4 and 1) on shared stimulus,
// checked against a period-counting reference model.
module tb_pwm_ramp_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [2:0] cmd_speed;
    logic       stop;

    logic       r4, h4, b4, a4;
    logic [2:0] s4;
    logic       r1, h1, b1, a1;
    logic [2:0] s1;
    logic [6:0] out4, out1;

    localparam logic [6:0] RST_OUT = 7'b1_000_1_0_1;

    assign out4 = {h4, s4, r4, b4, a4};
    assign out1 = {h1, s1, r1, b1, a1};

    always #5 clock = ~clock;

    pwm_ramp_ctrl #(.STEP_PERIODS(4)) dut4 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
        .cmd_ready(r4), .stop(stop), .pwm_hold(h4), .speed(s4), .busy(b4), .at_target(a4));

    pwm_ramp_ctrl #(.STEP_PERIODS(1)) dut1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
        .cmd_ready(r1), .stop(stop), .pwm_hold(h1), .speed(s1), .busy(b1), .at_target(a1));

    int checks = 0;
    int fails  = 0;

    // Reference model: speed derived from the count of whole periods since the command.
    int sp_v[2] = '{4, 1};
    bit m_hold[2];
    bit m_ramp[2];
    int m_dir[2];
    int m_speed[2];
    int m_target[2];
    int m_run[2];
    int m_wraps[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1; m_ramp[i] = 0; m_dir[i] = 0;
            m_speed[i] = 0; m_target[i] = 0; m_run[i] = 0; m_wraps[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            bit wrap;
            acc = cmd_valid && !m_ramp[i] && !stop;
            if (stop) begin
                m_hold[i] = 1; m_ramp[i] = 0; m_speed[i] = 0;
                m_target[i] = 0; m_run[i] = 0; m_wraps[i] = 0;
            end else begin
                wrap = !m_hold[i] && (m_run[i] % 32 == 31);
                if (!m_hold[i]) m_run[i]++;
                if (m_ramp[i] && wrap) begin
                    m_wraps[i]++;
                    if (m_wraps[i] % sp_v[i] == 0) begin
                        m_speed[i] += m_dir[i];
                        if (m_speed[i] == m_target[i]) begin
                            m_ramp[i] = 0;
                            if (m_target[i] == 0) begin
                                m_hold[i] = 1;
                                m_run[i] = 0;
                            end
                        end
                    end
                end else if (acc) begin
                    m_target[i] = int'(cmd_speed);
                    m_wraps[i] = 0;
                    if (m_hold[i]) begin
                        if (cmd_speed != 3'd0) begin
                            m_hold[i] = 0; m_run[i] = 0; m_ramp[i] = 1; m_dir[i] = 1;
                        end
                    end else if (int'(cmd_speed) > m_speed[i]) begin
                        m_ramp[i] = 1; m_dir[i] = 1;
                    end else if (int'(cmd_speed) < m_speed[i]) begin
                        m_ramp[i] = 1; m_dir[i] = -1;
                    end
                end
            end
        end
    endtask

    function automatic logic [6:0] m_out(int i);
        logic rdy, at;
        rdy = !m_ramp[i] && !stop;
        at  = !m_ramp[i] && (m_speed[i] == m_target[i]);
        return {m_hold[i], 3'(m_speed[i]), rdy, m_ramp[i], at};
    endfunction

    function automatic logic [6:0] d_out(int i);
        return (i == 0) ? out4 : out1;
    endfunction

    task automatic tick();
        if (reset) model_reset();
        else model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; cmd_valid = 0; cmd_speed = 0; stop = 0;
        tick(); tick(); tick();
        reset = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d_out(i) !== RST_OUT) begin
                fails++;
                $display("FAIL reset_out[%0d]: got %b want %b", i, d_out(i), RST_OUT);
            end
        end
        for (int c = 0; c < 100; c++) begin
            cmd_speed = 3'($urandom);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_out(i) !== RST_OUT) begin
                    fails++;
                    $display("FAIL idle_stable[%0d] cyc %0d: got %b want %b", i, c, d_out(i), RST_OUT);
                end
            end
        end
        checks++;
        if (dut4.phase !== 5'd0) begin
            fails++;
            $display("FAIL idle_phase: got %0d want 0", dut4.phase);
        end
    endtask

    task automatic test_ramp_up();
        logic [2:0] exp_s;
        cmd_speed = 3'd3; cmd_valid = 1;
        #1;
        checks++;
        if (r4 !== 1'b1) begin fails++; $display("FAIL up_ready_pre: got %b want 1", r4); end
        tick();
        cmd_valid = 0;
        checks++;
        if ({h4, b4, r4} !== 3'b010) begin
            fails++; $display("FAIL up_start: hold/busy/ready got %b want 010", {h4, b4, r4});
        end
        for (int k = 1; k <= 400; k++) begin
            tick();
            exp_s = (k >= 384) ? 3'd3 : (k >= 256) ? 3'd2 : (k >= 128) ? 3'd1 : 3'd0;
            checks++;
            if ({s4, b4, r4} !== {exp_s, k < 384, k >= 384}) begin
                fails++;
                $display("FAIL up_seq k=%0d: speed/busy/ready got %b want %b", k, {s4, b4, r4},
                         {exp_s, k < 384, k >= 384});
            end
            if (k == 128 || k == 256 || k == 384) begin
                checks++;
                if (dut4.phase !== 5'd0) begin
                    fails++; $display("FAIL up_phase_wrap k=%0d: got %0d want 0", k, dut4.phase);
                end
            end
            checks++;
            if (out1 !== m_out(1)) begin
                fails++; $display("FAIL up_model1 k=%0d: got %b want %b", k, out1, m_out(1));
            end
        end
        checks++;
        if ({a4, h4} !== 2'b10) begin fails++; $display("FAIL up_at_target: got %b want 10", {a4, h4}); end
    endtask

    task automatic test_hold_down();
        int last_chg;
        int n_chg;
        logic [4:0] prev_ph;
        logic [2:0] prev_s;
        bit done;
        cmd_speed = 3'd5; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_out(i) !== m_out(i)) begin
                    fails++; $display("FAIL to5_model[%0d] c=%0d: got %b want %b", i, c, d_out(i), m_out(i));
                end
            end
            done = !b4 && !b1;
        end
        checks++;
        if (!done || s4 !== 3'd5) begin fails++; $display("FAIL to5_done: speed %0d busy %b want 5 0", s4, b4); end

        cmd_speed = 3'd2; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        last_chg = -1; n_chg = 0; done = 0;
        for (int c = 1; c < 1000 && !done; c++) begin
            prev_ph = dut4.phase;
            prev_s = s4;
            tick();
            checks++;
            if (dut4.phase !== prev_ph + 5'd1) begin
                fails++; $display("FAIL down_phase c=%0d: got %0d want %0d", c, dut4.phase, prev_ph + 5'd1);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_out(i) !== m_out(i)) begin
                    fails++; $display("FAIL down_model[%0d] c=%0d: got %b want %b", i, c, d_out(i), m_out(i));
                end
            end
            if (s4 !== prev_s) begin
                n_chg++;
                checks++;
                if (s4 !== prev_s - 3'd1 || dut4.phase !== 5'd0) begin
                    fails++; $display("FAIL down_step c=%0d: speed %0d phase %0d", c, s4, dut4.phase);
                end
                if (last_chg >= 0) begin
                    checks++;
                    if (c - last_chg != 128) begin
                        fails++; $display("FAIL down_interval: got %0d want 128", c - last_chg);
                    end
                end
                last_chg = c;
            end
            done = !b4;
        end
        checks++;
        if (n_chg != 3 || s4 !== 3'd2) begin
            fails++; $display("FAIL down_result: steps %0d speed %0d want 3 2", n_chg, s4);
        end

        cmd_speed = 3'd2; cmd_valid = 1;
        #1;
        checks++;
        if (r4 !== 1'b1) begin fails++; $display("FAIL same_ready: got %b want 1", r4); end
        tick();
        cmd_valid = 0;
        for (int c = 0; c < 50; c++) begin
            checks++;
            if ({b4, s4, a4} !== 5'b0_010_1) begin
                fails++; $display("FAIL same_hold c=%0d: busy/speed/at got %b want 0_010_1", c, {b4, s4, a4});
            end
            tick();
        end
    endtask

    task automatic test_to_zero();
        bit done;
        cmd_speed = 3'd0; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_out(i) !== m_out(i)) begin
                    fails++; $display("FAIL zero_model[%0d] c=%0d: got %b want %b", i, c, d_out(i), m_out(i));
                end
            end
            if (s4 == 3'd0) begin
                done = 1;
                checks++;
                if (h4 !== 1'b1) begin fails++; $display("FAIL zero_hold_same_edge: got %b want 1", h4); end
            end
        end
        checks++;
        if (!done || dut4.phase !== 5'd0 || {r4, b4} !== 2'b10) begin
            fails++; $display("FAIL zero_idle: done %b phase %0d ready/busy %b", done, dut4.phase, {r4, b4});
        end
    endtask

    task automatic test_stop();
        cmd_speed = 3'd5; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        for (int k = 1; k < 128; k++) begin
            tick();
            checks++;
            if (out4 !== m_out(0)) begin
                fails++; $display("FAIL stop_pre k=%0d: got %b want %b", k, out4, m_out(0));
            end
        end
        checks++;
        if (dut4.phase !== 5'd31 || dut4.step_cnt !== 8'd3) begin
            fails++; $display("FAIL stop_align: phase %0d step_cnt %0d want 31 3", dut4.phase, dut4.step_cnt);
        end
        stop = 1; cmd_valid = 1; cmd_speed = 3'd6;
        #1;
        checks++;
        if ({r4, r1} !== 2'b00) begin fails++; $display("FAIL stop_ready: got %b want 00", {r4, r1}); end
        tick();
        checks++;
        if ({h4, s4, b4, dut4.target} !== {1'b1, 3'd0, 1'b0, 3'd0}) begin
            fails++; $display("FAIL stop_result: hold %b speed %0d busy %b target %0d", h4, s4, b4, dut4.target);
        end
        stop = 0; cmd_valid = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d_out(i) !== RST_OUT) begin
                fails++; $display("FAIL stop_after[%0d]: got %b want %b", i, d_out(i), RST_OUT);
            end
        end
    endtask

    task automatic test_async_reset();
        bit done;
        cmd_speed = 3'd6; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            tick();
            done = !b4;
        end
        checks++;
        if (!done || s4 !== 3'd6) begin fails++; $display("FAIL ar_setup: speed %0d busy %b", s4, b4); end
        cmd_speed = 3'd1; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        for (int c = 0; c < 200; c++) tick();
        checks++;
        if (out4 !== m_out(0) || b4 !== 1'b1) begin
            fails++; $display("FAIL ar_ramp_down: got %b want %b", out4, m_out(0));
        end
        #2;
        reset = 1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d_out(i) !== RST_OUT) begin
                fails++; $display("FAIL ar_immediate[%0d]: got %b want %b", i, d_out(i), RST_OUT);
            end
        end
        checks++;
        if (dut4.phase !== 5'd0) begin fails++; $display("FAIL ar_phase: got %0d want 0", dut4.phase); end
        tick(); tick();
        reset = 0;
        tick();
        checks++;
        if (out4 !== RST_OUT) begin fails++; $display("FAIL ar_release: got %b want %b", out4, RST_OUT); end
    endtask

    task automatic test_full_ramp();
        int k1, k4;
        k1 = -1; k4 = -1;
        cmd_speed = 3'd7; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        for (int k = 1; k <= 1000 && k4 < 0; k++) begin
            tick();
            if (k1 < 0 && s1 == 3'd7 && !b1) k1 = k;
            if (k4 < 0 && s4 == 3'd7 && !b4) k4 = k;
            checks++;
            if (out1 !== m_out(1)) begin
                fails++; $display("FAIL full_model1 k=%0d: got %b want %b", k, out1, m_out(1));
            end
        end
        checks++;
        if (k1 != 224) begin fails++; $display("FAIL full_sp1: got %0d cycles want 224", k1); end
        checks++;
        if (k4 != 896) begin fails++; $display("FAIL full_sp4: got %0d cycles want 896", k4); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom % 4) == 0;
            cmd_speed = 3'($urandom);
            stop = ($urandom % 150) == 0;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_out(i) !== m_out(i)) begin
                    fails++; $display("FAIL rand_model[%0d] c=%0d: got %b want %b", i, c, d_out(i), m_out(i));
                end
            end
        end
        stop = 0; cmd_valid = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_hold_down();
        test_to_zero();
        test_stop();
        test_async_reset();
        test_full_ramp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
